// File: rtl/comparator_sweep_checker.sv
// comparator_sweep_checker
//   Drives a WIDTH-bit magnitude comparator through every (ab, cd) operand
//   pair. Each pair is held for SETTLE cycles before the comparator flags are
//   checked against {ab>cd, ab==cd, ab<cd}. The block reports pass/fail, a
//   saturating error count and the first failing pair.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               sweep request, honoured in IDLE or DONE only
//   ab, cd              registered operands to the comparator
//   f1, f2, f3          comparator flags (gt, eq, lt)
//   busy                sweep in progress (WAIT or CHECK)
//   done                sweep finished; held until restart or reset
//   pass                in DONE, high iff no mismatches were seen
//   err_count           mismatching vectors in the current/last sweep
//   first_err_ab/_cd    operands of the first mismatching vector
module comparator_sweep_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   ab,
  output logic [WIDTH-1:0]   cd,
  input  logic               f1,
  input  logic               f2,
  input  logic               f3,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   first_err_ab,
  output logic [WIDTH-1:0]   first_err_cd
);

  // Counter only needs to hold SETTLE-1.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);
  localparam int EW = 2*WIDTH + 1;

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2:0]     exp_f;
  logic           mismatch;
  logic [EW-1:0]  err_next;
  logic           last_vec;

  always_comb begin
    exp_f    = {ab > cd, ab == cd, ab < cd};
    // Any deviation counts, including non-one-hot flag patterns.
    mismatch = ({f1, f2, f3} != exp_f);
    err_next = err_count;
    if (mismatch && (err_count != '1)) err_next = err_count + 1'b1;
    last_vec = (ab == '1) && (cd == '1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ab           <= '0;
      cd           <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      first_err_ab <= '0;
      first_err_cd <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE holds every output until a new start arrives.
          if (start) begin
            state        <= WAIT;
            ab           <= '0;
            cd           <= '0;
            cnt          <= RELOAD;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            first_err_ab <= '0;
            first_err_cd <= '0;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= CHECK;
          else           cnt   <= cnt - 1'b1;
        end
        CHECK: begin
          err_count <= err_next;
          if (mismatch && (err_count == '0)) begin
            first_err_ab <= ab;
            first_err_cd <= cd;
          end
          if (last_vec) begin
            // Operands stay at their final values in DONE.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            // cd is the inner loop, ab the outer loop.
            if (cd == '1) begin
              cd <= '0;
              ab <= ab + 1'b1;
            end else begin
              cd <= cd + 1'b1;
            end
            cnt   <= RELOAD;
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
